// File: rtl/morph_pkg.sv
// Shared opcodes, instruction layout and FSM states for the morphological program engine.
package morph_pkg;

  localparam int unsigned InstrWidth = 17;
  localparam int unsigned ElWidth    = 9;
  localparam int unsigned OpWidth    = 3;

  localparam logic [OpWidth-1:0] MORPH_ERODE    = 3'd0;
  localparam logic [OpWidth-1:0] MORPH_DILATE   = 3'd1;
  localparam logic [OpWidth-1:0] MORPH_OPEN     = 3'd2;
  localparam logic [OpWidth-1:0] MORPH_CLOSE    = 3'd3;
  localparam logic [OpWidth-1:0] MORPH_IDENTITY = 3'd4;

  localparam logic [OpWidth-1:0] LOGIC_B    = 3'd0;
  localparam logic [OpWidth-1:0] LOGIC_AND  = 3'd1;
  localparam logic [OpWidth-1:0] LOGIC_OR   = 3'd2;
  localparam logic [OpWidth-1:0] LOGIC_XOR  = 3'd3;
  localparam logic [OpWidth-1:0] LOGIC_ANDN = 3'd4;
  localparam logic [OpWidth-1:0] LOGIC_A    = 3'd5;
  localparam logic [OpWidth-1:0] LOGIC_NOTB = 3'd6;
  localparam logic [OpWidth-1:0] LOGIC_ZERO = 3'd7;

  // Field order fixes the bit positions: el [16:8], morph_op [7:5], morph_src [4],
  // logic_op [3:1], last [0].
  typedef struct packed {
    logic [ElWidth-1:0] el;
    logic [OpWidth-1:0] morph_op;
    logic               morph_src;
    logic [OpWidth-1:0] logic_op;
    logic               last;
  } instr_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

endpackage

// File: rtl/morph_prog_mem.sv
// Instruction store: one synchronous write port, one asynchronous read port, no reset.
module morph_prog_mem
  import morph_pkg::*;
#(
  parameter int unsigned ProgDepth = 8,
  parameter int unsigned PcWidth   = $clog2(ProgDepth)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [PcWidth-1:0]    waddr,
  input  logic [InstrWidth-1:0] wdata,
  input  logic [PcWidth-1:0]    raddr,
  output logic [InstrWidth-1:0] rdata
);

  logic [InstrWidth-1:0] mem_q [ProgDepth];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/morph_program_engine.sv
// Programmable multi-step morphological processor with start/busy/done handshake.
// Optional cycleCount output enabled by defining MORPH_PROG_CYCLE_COUNT_EN.
module morph_program_engine
  import morph_pkg::*;
#(
  parameter int unsigned ImageWidth  = 16,
  parameter int unsigned ImageHeight = 16,
  parameter int unsigned ProgDepth   = 8,
  parameter int unsigned PcWidth     = $clog2(ProgDepth)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              progWe,
  input  logic [PcWidth-1:0]                progAddr,
  input  logic [InstrWidth-1:0]             progData,
  input  logic                              start,
  input  logic [ImageWidth*ImageHeight-1:0] image,
  output logic                              busy,
  output logic                              done,
  output logic [PcWidth-1:0]                pc,
  output logic [ImageWidth*ImageHeight-1:0] result
`ifdef MORPH_PROG_CYCLE_COUNT_EN
  , output logic [15:0]                     cycleCount
`endif
);

  localparam int unsigned NumPix   = ImageWidth * ImageHeight;
  localparam int unsigned IdxWidth = $clog2(NumPix);

  state_e              state_q, state_d;
  logic [PcWidth-1:0]  pc_q, pc_d;
  logic [NumPix-1:0]   result_q, result_d;
  logic [NumPix-1:0]   in_q, in_d;
  logic [InstrWidth-1:0] rd_data;
  instr_t              instr;
  logic [NumPix-1:0]   src, er, di, morph_b, logic_out;

  // Pixel (r, c) lives at bit r*ImageWidth + c; out-of-image pixels read as `outside`.
  function automatic logic get_pix(input logic [NumPix-1:0] img, input int r, input int c,
                                   input logic outside);
    logic v;
    if (r < 0 || r >= int'(ImageHeight) || c < 0 || c >= int'(ImageWidth)) v = outside;
    else v = img[IdxWidth'(r * int'(ImageWidth) + c)];
    return v;
  endfunction

  // Element bit k covers offset (k/3-1, k%3-1); bit 4 is the centre.
  function automatic logic [NumPix-1:0] erode(input logic [NumPix-1:0] img,
                                              input logic [ElWidth-1:0] el);
    logic [NumPix-1:0] o;
    logic acc;
    o = '0;
    for (int r = 0; r < int'(ImageHeight); r++) begin
      for (int c = 0; c < int'(ImageWidth); c++) begin
        acc = 1'b1;
        for (int k = 0; k < 9; k++) begin
          if (el[4'(k)]) acc &= get_pix(img, r + k / 3 - 1, c + k % 3 - 1, 1'b1);
        end
        o[IdxWidth'(r * int'(ImageWidth) + c)] = acc;
      end
    end
    return o;
  endfunction

  // Dilation uses the reflected element so open/close stay dual for asymmetric elements.
  function automatic logic [NumPix-1:0] dilate(input logic [NumPix-1:0] img,
                                               input logic [ElWidth-1:0] el);
    logic [NumPix-1:0] o;
    logic acc;
    o = '0;
    for (int r = 0; r < int'(ImageHeight); r++) begin
      for (int c = 0; c < int'(ImageWidth); c++) begin
        acc = 1'b0;
        for (int k = 0; k < 9; k++) begin
          if (el[4'(k)]) acc |= get_pix(img, r - (k / 3 - 1), c - (k % 3 - 1), 1'b0);
        end
        o[IdxWidth'(r * int'(ImageWidth) + c)] = acc;
      end
    end
    return o;
  endfunction

  morph_prog_mem #(
    .ProgDepth (ProgDepth),
    .PcWidth   (PcWidth)
  ) u_prog_mem (
    .clk   (clk),
    .we    (progWe && (state_q != StRun)),
    .waddr (progAddr),
    .wdata (progData),
    .raddr (pc_q),
    .rdata (rd_data)
  );

  assign instr = instr_t'(rd_data);

  always_comb begin
    src = instr.morph_src ? in_q : result_q;
    er  = erode(src, instr.el);
    di  = dilate(src, instr.el);
    case (instr.morph_op)
      MORPH_ERODE:    morph_b = er;
      MORPH_DILATE:   morph_b = di;
      MORPH_OPEN:     morph_b = dilate(er, instr.el);
      MORPH_CLOSE:    morph_b = erode(di, instr.el);
      MORPH_IDENTITY: morph_b = src;
      default:        morph_b = src;
    endcase
    case (instr.logic_op)
      LOGIC_B:    logic_out = morph_b;
      LOGIC_AND:  logic_out = result_q & morph_b;
      LOGIC_OR:   logic_out = result_q | morph_b;
      LOGIC_XOR:  logic_out = result_q ^ morph_b;
      LOGIC_ANDN: logic_out = result_q & ~morph_b;
      LOGIC_A:    logic_out = result_q;
      LOGIC_NOTB: logic_out = ~morph_b;
      LOGIC_ZERO: logic_out = '0;
      default:    logic_out = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    result_d = result_q;
    in_d     = in_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          in_d     = image;
          result_d = image;
          pc_d     = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        result_d = logic_out;
        if (instr.last || pc_q == PcWidth'(ProgDepth - 1)) state_d = StDone;
        else pc_d = pc_q + 1'b1;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      pc_q     <= '0;
      result_q <= '0;
      in_q     <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      result_q <= result_d;
      in_q     <= in_d;
    end
  end

  assign busy   = (state_q == StRun);
  assign done   = (state_q == StDone);
  assign pc     = pc_q;
  assign result = result_q;

`ifdef MORPH_PROG_CYCLE_COUNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else if (state_q == StIdle && start) cnt_q <= '0;
    else if (state_q == StRun && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
  end

  assign cycleCount = cnt_q;
`endif

endmodule
